// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device over the open-drain
// clock/data pair. The sequence is: inhibit the clock, request-to-send by
// driving the start bit, then shift out 8 data bits, odd parity and stop on
// device-generated falling edges. After that the device ack bit is sampled,
// and the block waits for both lines to be released.
//
// Ports
//   clk, rst          system clock (posedge), asynchronous active-high reset
//   tx_data/valid     byte to send; accepted when tx_valid && tx_ready
//   tx_ready          high only while idle
//   ps2_clk_in/_data_in   sensed line levels (asynchronous to clk)
//   ps2_clk_oe/_data_oe   1 = pull line low, 0 = release
//   busy              high whenever a transaction is in progress
//   done              one-cycle pulse at the end of every transaction
//   ack_ok, timeout   transaction status, valid with done, held until next accept
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    // One shared counter covers both the inhibit interval and the timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_REL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic             timeout_q, timeout_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;

    logic ps2_fall;
    logic clk_synced;
    logic data_synced;

    assign ps2_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign clk_synced  = clk_sync_q[1];
    assign data_synced = data_sync_q[1];

    assign ack_ok  = ack_ok_q;
    assign timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            data_oe_q   <= 1'b0;
            ack_ok_q    <= 1'b0;
            timeout_q   <= 1'b0;
            // Clock chain resets high so the first sample cannot look like a falling edge.
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            data_oe_q   <= data_oe_d;
            ack_ok_q    <= ack_ok_d;
            timeout_q   <= timeout_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        data_oe_d   = data_oe_q;
        ack_ok_d    = ack_ok_q;
        timeout_d   = timeout_q;
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};

        tx_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    // Frame is held LSB first: d0..d7, odd parity, stop.
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_REQ: begin
                // Start bit: data pulled low while the clock is still held.
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                cnt_d       = '0;
                bit_cnt_d   = '0;
                data_oe_d   = 1'b1;
                state_d     = S_SEND;
            end

            S_SEND: begin
                ps2_data_oe = data_oe_q;
                if (ps2_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Tenth edge puts the stop bit (a release) on the line.
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (ps2_fall) begin
                    ack_ok_d = ~data_synced;
                    state_d  = S_WAIT_REL;
                end
            end

            S_WAIT_REL: begin
                if (clk_synced && data_synced) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The timeout overrides whatever the device-driven phases decided.
        if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_REL) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
                ack_ok_d  = 1'b0;
                data_oe_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL provide parameters: INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, 1000000, max clk cycles from end of inhibit to frame completion.
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-006 SHALL have port tx_valid  input  1  request; accepted when tx_valid && tx_ready.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have ports ps2_clk_in, ps2_data_in  input  1 each  sensed open-drain line levels.
REQ-009 SHALL have ports ps2_clk_oe, ps2_data_oe  output  1 each  1 = drive line low, 0 = release.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of each transaction.
REQ-012 SHALL have ports ack_ok, timeout  output  1 each  status, valid in the done cycle, held until next acceptance.

Function
REQ-013 SHALL synchronise ps2_clk_in through a 3-flop chain and ps2_data_in through 2 flops; ps2 falling edge = sync[2] high and sync[1] low.
REQ-014 SHALL, on acceptance, latch tx_data and odd parity bit p = ~^tx_data, then enter INHIBIT.
REQ-015 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL, DONE.
REQ-016 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-017 REQ: ps2_clk_oe=1, ps2_data_oe=1 for exactly 1 cycle (start bit), then SEND with timeout counter cleared.
REQ-018 SEND: ps2_clk_oe=0; ps2_data_oe stays 1 until the first ps2 falling edge.
REQ-019 SEND: on falling edge k (k=1..10) ps2_data_oe SHALL become ~frame[k-1], frame = {d0..d7, p, stop=1}, LSB first; after edge 10 data is released; then ACK.
REQ-020 ACK: on the next ps2 falling edge, ack_ok <= (synced data == 0); then WAIT_REL.
REQ-021 WAIT_REL: wait until synced clock and data are both 1, then DONE.
REQ-022 DONE: done=1 for one cycle, next state IDLE; tx_ready stays 0 in DONE.
REQ-023 Timeout counter SHALL run in SEND, ACK and WAIT_REL; on reaching TIMEOUT_CYCLES, release both lines, set timeout=1, ack_ok=0, go DONE.
REQ-024 tx_valid outside IDLE SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-025 A falling edge in IDLE, INHIBIT or REQ SHALL be ignored (no state change).
REQ-026 Bit counter SHALL be 4 bits, cleared on entering SEND, never wrap past 10.

Reset
REQ-027 rst high SHALL asynchronously force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 (after release), busy=0, done=0, ack_ok=0, timeout=0, counters and sync flops to 0 (clock sync to 1 so no false edge).
REQ-028 rst asserted mid-frame SHALL release both lines in the same cycle with no done pulse.

Verification
REQ-029 tx_data=0xED, device model clocks at 12 kHz and acks -> data line bits 1,0,1,1,0,1,1,1, p=1, stop=1; done pulse, ack_ok=1, timeout=0.
REQ-030 tx_data=0x07 -> parity bit 0 on edge 9; tx_data=0xFF -> parity 1; 0x00 -> parity 1.
REQ-031 Device never clocks after REQ -> ps2_clk_oe=0, data released, done after TIMEOUT_CYCLES with timeout=1, ack_ok=0.
REQ-032 Device omits ack (data high on edge 11) -> done, ack_ok=0, timeout=0.
REQ-033 rst pulse at falling edge 4 -> both oe 0 immediately, tx_ready=1, no done; new 0xF4 send then completes with ack_ok=1.
REQ-034 tx_valid held high continuously, two bytes 0xED then 0x02 -> exactly two frames, second accepted cycle after done, INHIBIT measured as 5000 cycles each.
